// File: rtl/branch_seq.sv
// branch_seq: PC register and conditional-branch sequencer for the
// 5-stage microinstruction pipeline. It advances PC unless HOLD is set,
// resolves BRZ/BRC when the branch reaches stage 4, and flushes the
// younger stages for FLUSH_CYCLES cycles after a taken branch.
// Optional feature macro: BRANCH_STATS_EN adds saturating taken/not-taken
// resolution counters (BR_CNT_TAKEN, BR_CNT_NOT).
module branch_seq #(
    parameter int              PC_W         = 8,
    parameter logic [PC_W-1:0] RESET_PC     = {PC_W{1'b0}},
    parameter int              FLUSH_CYCLES = 3
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            HOLD,
    input  logic            BRANCH_UPDATE,
    input  logic [6:0]      T4,
    input  logic [PC_W-1:0] BR_TARGET,
    input  logic            CY,
    input  logic            WZ,
    output logic [PC_W-1:0] PC,
    output logic            FETCH_EN,
    output logic            FLUSH,
    output logic            BR_TAKEN,
    output logic            BUSY
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]     BR_CNT_TAKEN,
    output logic [15:0]     BR_CNT_NOT
`endif
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [6:0]      T4_BRZ     = 7'b1000001;
    localparam logic [6:0]      T4_BRC     = 7'b1010000;
    localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_CYCLES);
    localparam logic [PC_W-1:0] PC_ONE     = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state_r;
    state_t          state_s;
    logic [2:0]      cnt_r;
    logic [2:0]      cnt_s;
    logic [PC_W-1:0] pc_s;
    logic            fetch_en_s;
    logic            flush_s;
    logic            br_taken_s;
    logic            busy_s;

    logic            is_brz_s;
    logic            is_brc_s;
    logic            resolve_s;
    logic            taken_s;

    // Decode the stage-4 branch; it only counts while running, since in
    // FLUSH the issuing microinstruction is being killed.
    always_comb begin
        is_brz_s  = (T4 == T4_BRZ);
        is_brc_s  = (T4 == T4_BRC);
        resolve_s = BRANCH_UPDATE && (state_r == ST_RUN);
        taken_s   = resolve_s && ((is_brz_s && WZ) || (is_brc_s && CY));
    end

    // Next-state, next-PC and next-output logic (outputs are registered).
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        pc_s       = PC;
        fetch_en_s = 1'b1;
        flush_s    = 1'b0;
        br_taken_s = 1'b0;
        busy_s     = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (taken_s) begin
                    // A taken branch overrides HOLD.
                    pc_s       = BR_TARGET;
                    cnt_s      = FLUSH_INIT;
                    state_s    = ST_FLUSH;
                    br_taken_s = 1'b1;
                    fetch_en_s = 1'b0;
                    flush_s    = 1'b1;
                    busy_s     = 1'b1;
                end else if (!HOLD) begin
                    pc_s = PC + PC_ONE;
                end else begin
                    pc_s = PC;
                end
            end
            ST_FLUSH: begin
                // cnt_r counts FLUSH cycles still to come including this one.
                if (cnt_r <= 3'd1) begin
                    cnt_s   = 3'd0;
                    state_s = ST_RUN;
                end else begin
                    cnt_s      = cnt_r - 3'd1;
                    fetch_en_s = 1'b0;
                    flush_s    = 1'b1;
                    busy_s     = 1'b1;
                end
            end
            default: begin
                cnt_s   = 3'd0;
                state_s = ST_RUN;
            end
        endcase
    end

    // State, PC and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_r  <= ST_RUN;
            cnt_r    <= 3'd0;
            PC       <= RESET_PC;
            FETCH_EN <= 1'b1;
            FLUSH    <= 1'b0;
            BR_TAKEN <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            PC       <= pc_s;
            FETCH_EN <= fetch_en_s;
            FLUSH    <= flush_s;
            BR_TAKEN <= br_taken_s;
            BUSY     <= busy_s;
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating counters of resolved BRZ/BRC outcomes; unknown T4 is skipped.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            BR_CNT_TAKEN <= 16'h0000;
            BR_CNT_NOT   <= 16'h0000;
        end else if (resolve_s && (is_brz_s || is_brc_s)) begin
            if (taken_s) begin
                if (BR_CNT_TAKEN != 16'hFFFF) begin
                    BR_CNT_TAKEN <= BR_CNT_TAKEN + 16'h0001;
                end
            end else begin
                if (BR_CNT_NOT != 16'hFFFF) begin
                    BR_CNT_NOT <= BR_CNT_NOT + 16'h0001;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_seq.sv
// Directed self-checking bench for branch_seq (RESET_PC = 8'h10).
module tb_branch_seq;

    logic       CLK;
    logic       RESET_N;
    logic       HOLD;
    logic       BRANCH_UPDATE;
    logic [6:0] T4;
    logic [7:0] BR_TARGET;
    logic       CY;
    logic       WZ;
    logic [7:0] PC;
    logic       FETCH_EN;
    logic       FLUSH;
    logic       BR_TAKEN;
    logic       BUSY;
`ifdef BRANCH_STATS_EN
    logic [15:0] BR_CNT_TAKEN;
    logic [15:0] BR_CNT_NOT;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [6:0] BRZ = 7'b1000001;
    localparam logic [6:0] BRC = 7'b1010000;

    branch_seq #(
        .PC_W(8),
        .RESET_PC(8'h10),
        .FLUSH_CYCLES(3)
    ) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .HOLD(HOLD),
        .BRANCH_UPDATE(BRANCH_UPDATE),
        .T4(T4),
        .BR_TARGET(BR_TARGET),
        .CY(CY),
        .WZ(WZ),
        .PC(PC),
        .FETCH_EN(FETCH_EN),
        .FLUSH(FLUSH),
        .BR_TAKEN(BR_TAKEN),
        .BUSY(BUSY)
`ifdef BRANCH_STATS_EN
        ,
        .BR_CNT_TAKEN(BR_CNT_TAKEN),
        .BR_CNT_NOT(BR_CNT_NOT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Check PC and the three level outputs in one go.
    task automatic check_state(input string tag, input logic [7:0] pc_e,
                               input logic fe_e, input logic fl_e, input logic bt_e);
        check({tag, ".pc"}, {8'h00, PC}, {8'h00, pc_e});
        check({tag, ".fetch_en"}, {15'h0000, FETCH_EN}, {15'h0000, fe_e});
        check({tag, ".flush"}, {15'h0000, FLUSH}, {15'h0000, fl_e});
        check({tag, ".busy"}, {15'h0000, BUSY}, {15'h0000, fl_e});
        check({tag, ".br_taken"}, {15'h0000, BR_TAKEN}, {15'h0000, bt_e});
    endtask

    task automatic branch(input logic [6:0] t4, input logic [7:0] tgt,
                          input logic cy, input logic wz);
        BRANCH_UPDATE = 1'b1;
        T4 = t4;
        BR_TARGET = tgt;
        CY = cy;
        WZ = wz;
    endtask

    task automatic idle();
        BRANCH_UPDATE = 1'b0;
        T4 = 7'b0000000;
        BR_TARGET = 8'h00;
        CY = 1'b0;
        WZ = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0;
        HOLD = 1'b0;
        idle();
        tick();
        tick();
        check_state("reset", 8'h10, 1'b1, 1'b0, 1'b0);
`ifdef BRANCH_STATS_EN
        check("reset.cnt_taken", BR_CNT_TAKEN, 16'h0000);
        check("reset.cnt_not", BR_CNT_NOT, 16'h0000);
`endif

        // Free-running increment from RESET_PC.
        RESET_N = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_state("run", 8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
        end

        // Taken BRC to 40 while HOLD is set (HOLD ignored on taken branch).
        HOLD = 1'b1;
        branch(BRC, 8'h40, 1'b1, 1'b0);
        tick();
        idle();
        HOLD = 1'b0;
        check_state("brc_f1", 8'h40, 1'b0, 1'b1, 1'b1);
        tick();
        check_state("brc_f2", 8'h40, 1'b0, 1'b1, 1'b0);
        tick();
        check_state("brc_f3", 8'h40, 1'b0, 1'b1, 1'b0);
        tick();
        check_state("brc_run", 8'h40, 1'b1, 1'b0, 1'b0);
        tick();
        check_state("brc_inc", 8'h41, 1'b1, 1'b0, 1'b0);

        // Taken BRZ to 20, then wait out the flush.
        branch(BRZ, 8'h20, 1'b0, 1'b1);
        tick();
        idle();
        check_state("brz_f1", 8'h20, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        check_state("brz_run", 8'h20, 1'b1, 1'b0, 1'b0);

        // Not-taken BRZ at PC=20.
        branch(BRZ, 8'h55, 1'b1, 1'b0);
        tick();
        check_state("brz_nt", 8'h21, 1'b1, 1'b0, 1'b0);
        // Back-to-back: unknown T4 with both flags set is never taken.
        branch(7'b0000001, 8'h66, 1'b1, 1'b1);
        tick();
        check_state("unk_t4", 8'h22, 1'b1, 1'b0, 1'b0);
        // Not-taken BRC under HOLD: PC frozen, branch consumed.
        HOLD = 1'b1;
        branch(BRC, 8'h77, 1'b0, 1'b1);
        tick();
        check_state("hold_nt", 8'h22, 1'b1, 1'b0, 1'b0);
        idle();
        tick();
        check_state("hold_nt2", 8'h22, 1'b1, 1'b0, 1'b0);
        HOLD = 1'b0;

        // Jump to FF, hold there, then wrap to 00.
        branch(BRC, 8'hFF, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        tick();
        tick();
        check_state("ff_run", 8'hFF, 1'b1, 1'b0, 1'b0);
        HOLD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state("ff_hold", 8'hFF, 1'b1, 1'b0, 1'b0);
        end
        HOLD = 1'b0;
        tick();
        check_state("wrap", 8'h00, 1'b1, 1'b0, 1'b0);

        // Taken BRC to 80; branch during 2nd flush cycle is ignored.
        branch(BRC, 8'h80, 1'b1, 1'b0);
        tick();
        idle();
        check_state("b80_f1", 8'h80, 1'b0, 1'b1, 1'b1);
        tick();
        check_state("b80_f2", 8'h80, 1'b0, 1'b1, 1'b0);
        branch(BRZ, 8'h90, 1'b0, 1'b1);
        tick();
        idle();
        check_state("b80_f3", 8'h80, 1'b0, 1'b1, 1'b0);
`ifdef BRANCH_STATS_EN
        check("stats.cnt_taken", BR_CNT_TAKEN, 16'h0004);
        check("stats.cnt_not", BR_CNT_NOT, 16'h0002);
`endif
        // Reset mid-flush wins.
        RESET_N = 1'b0;
        tick();
        check_state("mid_rst", 8'h10, 1'b1, 1'b0, 1'b0);
`ifdef BRANCH_STATS_EN
        check("mid_rst.cnt_taken", BR_CNT_TAKEN, 16'h0000);
        check("mid_rst.cnt_not", BR_CNT_NOT, 16'h0000);
`endif
        RESET_N = 1'b1;
        tick();
        check_state("post_rst", 8'h11, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
